// File: rtl/ysyx_041461_clint_pkg.sv
// rtl/ysyx_041461_clint_pkg.sv - shared types, response codes, address defaults and helpers for the CLINT
// Contents: read/write FSM state encodings, decode targets, AXI response codes,
// default register addresses, byte-merge and read-mux helpers.
package ysyx_041461_clint_pkg;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_MTIME,
        TGT_MTIMECMP,
        TGT_MSIP
    } tgt_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] MTIME_ADDR_DEF    = 32'h0200_bff8;
    localparam logic [31:0] MTIMECMP_ADDR_DEF = 32'h0200_4000;
    localparam logic [31:0] MSIP_ADDR_DEF     = 32'h0200_0000;

    // Replace the bytes of old_v selected by strb with the matching bytes of new_v.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

    // Unmapped targets read as zero.
    function automatic logic [63:0] read_mux(input tgt_e        tgt,
                                             input logic [63:0] mtime,
                                             input logic [63:0] mtimecmp,
                                             input logic        msip);
        case (tgt)
            TGT_MTIME:    return mtime;
            TGT_MTIMECMP: return mtimecmp;
            TGT_MSIP:     return {63'd0, msip};
            default:      return 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_041461_clint_timer.sv
// rtl/ysyx_041461_clint_timer.sv - prescaled mtime counter, mtimecmp storage and timer interrupt compare
// Ports: clk, rst_n (async active-low); mtime_we_i / mtimecmp_we_i select the
// register written this cycle with wdata_i under wstrb_i; mtime_o, mtimecmp_o
// expose current values; timer_int_o is the registered (mtime >= mtimecmp).
module ysyx_041461_clint_timer
    import ysyx_041461_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtime_we_i,
    input  logic        mtimecmp_we_i,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  wstrb_i,
    output logic [63:0] mtime_o,
    output logic [63:0] mtimecmp_o,
    output logic        timer_int_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          timer_int_q;
    logic          tick;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PW'(1);
        // A software write beats the tick; the prescaler keeps running regardless.
        if (mtime_we_i) begin
            mtime_d = byte_merge(mtime_q, wdata_i, wstrb_i);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
        mtimecmp_d = mtimecmp_we_i ? byte_merge(mtimecmp_q, wdata_i, wstrb_i) : mtimecmp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= '1;
            timer_int_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            timer_int_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign mtime_o     = mtime_q;
    assign mtimecmp_o  = mtimecmp_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: rtl/ysyx_041461_clint.sv
// rtl/ysyx_041461_clint.sv - AXI4 slave core-local interruptor (mtime, mtimecmp, timer interrupt)
// Ports: clk, rst_n (async active-low); CLINT_aw*/w*/b* write channels;
// CLINT_ar*/r* read channels; timer_int to trap logic; soft_int only when
// YSYX_041461_CLINT_MSIP_EN is defined (adds msip at 0x0200_0000).
module ysyx_041461_clint
    import ysyx_041461_clint_pkg::*;
#(
    parameter int unsigned  TICK_DIV      = 1,
    parameter logic [31:0]  MTIME_ADDR    = MTIME_ADDR_DEF,
    parameter logic [31:0]  MTIMECMP_ADDR = MTIMECMP_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        CLINT_awvalid,
    output logic        CLINT_awready,
    input  logic [3:0]  CLINT_awid,
    input  logic [31:0] CLINT_awaddr,
    input  logic [7:0]  CLINT_awlen,
    input  logic [2:0]  CLINT_awsize,
    input  logic [1:0]  CLINT_awburst,
    input  logic        CLINT_wvalid,
    output logic        CLINT_wready,
    input  logic [63:0] CLINT_wdata,
    input  logic [7:0]  CLINT_wstrb,
    input  logic        CLINT_wlast,
    output logic        CLINT_bvalid,
    input  logic        CLINT_bready,
    output logic [3:0]  CLINT_bid,
    output logic [1:0]  CLINT_bresp,
    input  logic        CLINT_arvalid,
    output logic        CLINT_arready,
    input  logic [3:0]  CLINT_arid,
    input  logic [31:0] CLINT_araddr,
    input  logic [7:0]  CLINT_arlen,
    input  logic [2:0]  CLINT_arsize,
    input  logic [1:0]  CLINT_arburst,
    output logic        CLINT_rvalid,
    input  logic        CLINT_rready,
    output logic [3:0]  CLINT_rid,
    output logic [1:0]  CLINT_rresp,
    output logic [63:0] CLINT_rdata,
    output logic        CLINT_rlast,
`ifdef YSYX_041461_CLINT_MSIP_EN
    output logic        soft_int,
`endif
    output logic        timer_int
);

    function automatic tgt_e decode(input logic [31:0] a);
        if (a[31:3] == MTIME_ADDR[31:3])    return TGT_MTIME;
        if (a[31:3] == MTIMECMP_ADDR[31:3]) return TGT_MTIMECMP;
`ifdef YSYX_041461_CLINT_MSIP_EN
        if (a[31:3] == MSIP_ADDR_DEF[31:3]) return TGT_MSIP;
`endif
        return TGT_NONE;
    endfunction

    r_state_e    r_state_q;
    tgt_e        rsel_q;
    logic [7:0]  rcnt_q;
    logic [3:0]  rid_q;
    logic [1:0]  rresp_q;
    logic [63:0] rdata_q;
    logic        rlast_q;

    w_state_e    w_state_q;
    tgt_e        wsel_q;
    logic [3:0]  bid_q;
    logic [1:0]  bresp_q;

    logic [63:0] mtime, mtimecmp;
    logic        msip_bit;
    logic        wbeat;
    tgt_e        ar_tgt, aw_tgt;

    assign ar_tgt = decode(CLINT_araddr);
    assign aw_tgt = decode(CLINT_awaddr);
    assign wbeat  = (w_state_q == W_DATA) && CLINT_wvalid;

    ysyx_041461_clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .mtime_we_i    (wbeat && (wsel_q == TGT_MTIME)),
        .mtimecmp_we_i (wbeat && (wsel_q == TGT_MTIMECMP)),
        .wdata_i       (CLINT_wdata),
        .wstrb_i       (CLINT_wstrb),
        .mtime_o       (mtime),
        .mtimecmp_o    (mtimecmp),
        .timer_int_o   (timer_int)
    );

`ifdef YSYX_041461_CLINT_MSIP_EN
    logic msip_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip_q <= 1'b0;
        end else if (wbeat && (wsel_q == TGT_MSIP) && CLINT_wstrb[0]) begin
            msip_q <= CLINT_wdata[0];
        end
    end
    assign msip_bit = msip_q;
    assign soft_int = msip_q;
`else
    assign msip_bit = 1'b0;
`endif

    // Read data is captured when each beat is offered, so a stalled beat keeps
    // a stable payload even though mtime keeps counting underneath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            rsel_q    <= TGT_NONE;
            rcnt_q    <= 8'd0;
            rid_q     <= 4'd0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= 64'd0;
            rlast_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (CLINT_arvalid) begin
                        r_state_q <= R_DATA;
                        rsel_q    <= ar_tgt;
                        rcnt_q    <= CLINT_arlen;
                        rid_q     <= CLINT_arid;
                        rresp_q   <= (ar_tgt == TGT_NONE) ? RESP_DECERR : RESP_OKAY;
                        rdata_q   <= read_mux(ar_tgt, mtime, mtimecmp, msip_bit);
                        rlast_q   <= (CLINT_arlen == 8'd0);
                    end
                end
                default: begin
                    if (CLINT_rready) begin
                        if (rcnt_q == 8'd0) begin
                            r_state_q <= R_IDLE;
                            rlast_q   <= 1'b0;
                        end else begin
                            rcnt_q  <= rcnt_q - 8'd1;
                            rlast_q <= (rcnt_q == 8'd1);
                            rdata_q <= read_mux(rsel_q, mtime, mtimecmp, msip_bit);
                        end
                    end
                end
            endcase
        end
    end

    // bresp is decided at AW time; unmapped beats are accepted and dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            wsel_q    <= TGT_NONE;
            bid_q     <= 4'd0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (CLINT_awvalid) begin
                        w_state_q <= W_DATA;
                        wsel_q    <= aw_tgt;
                        bid_q     <= CLINT_awid;
                        bresp_q   <= (aw_tgt == TGT_NONE) ? RESP_DECERR : RESP_OKAY;
                    end
                end
                W_DATA: begin
                    if (CLINT_wvalid && CLINT_wlast) begin
                        w_state_q <= W_RESP;
                    end
                end
                default: begin
                    if (CLINT_bready) begin
                        w_state_q <= W_IDLE;
                    end
                end
            endcase
        end
    end

    assign CLINT_arready = (r_state_q == R_IDLE);
    assign CLINT_rvalid  = (r_state_q == R_DATA);
    assign CLINT_rid     = rid_q;
    assign CLINT_rresp   = rresp_q;
    assign CLINT_rdata   = rdata_q;
    assign CLINT_rlast   = rlast_q;
    assign CLINT_awready = (w_state_q == W_IDLE);
    assign CLINT_wready  = (w_state_q == W_DATA);
    assign CLINT_bvalid  = (w_state_q == W_RESP);
    assign CLINT_bid     = bid_q;
    assign CLINT_bresp   = bresp_q;

    // Burst shape fields and sub-word address bits do not affect this slave.
    logic unused_ok;
    assign unused_ok = ^{CLINT_awlen, CLINT_awsize, CLINT_awburst, CLINT_arsize,
                         CLINT_arburst, CLINT_awaddr[2:0], CLINT_araddr[2:0]};

endmodule

// File: tb/tb_ysyx_041461_clint.sv
// tb/tb_ysyx_041461_clint.sv - scoreboard bench for the CLINT AXI slave
module tb_ysyx_041461_clint;

    localparam logic [31:0] A_MTIME = 32'h0200_bff8;
    localparam logic [31:0] A_CMP   = 32'h0200_4000;
    localparam logic [31:0] A_BAD   = 32'h0200_1000;
    localparam logic [31:0] A_MSIP  = 32'h0200_0000;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  DECERR  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen, wstrb;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [63:0] wdata, rdata;
    logic        arvalid, arready, rvalid, rready, rlast, timer_int;
`ifdef YSYX_041461_CLINT_MSIP_EN
    logic        soft_int;
`endif

    always #5 clk = ~clk;

    ysyx_041461_clint dut (
        .clk(clk), .rst_n(rst_n),
        .CLINT_awvalid(awvalid), .CLINT_awready(awready), .CLINT_awid(awid),
        .CLINT_awaddr(awaddr), .CLINT_awlen(awlen), .CLINT_awsize(awsize),
        .CLINT_awburst(awburst), .CLINT_wvalid(wvalid), .CLINT_wready(wready),
        .CLINT_wdata(wdata), .CLINT_wstrb(wstrb), .CLINT_wlast(wlast),
        .CLINT_bvalid(bvalid), .CLINT_bready(bready), .CLINT_bid(bid),
        .CLINT_bresp(bresp), .CLINT_arvalid(arvalid), .CLINT_arready(arready),
        .CLINT_arid(arid), .CLINT_araddr(araddr), .CLINT_arlen(arlen),
        .CLINT_arsize(arsize), .CLINT_arburst(arburst), .CLINT_rvalid(rvalid),
        .CLINT_rready(rready), .CLINT_rid(rid), .CLINT_rresp(rresp),
        .CLINT_rdata(rdata), .CLINT_rlast(rlast),
`ifdef YSYX_041461_CLINT_MSIP_EN
        .soft_int(soft_int),
`endif
        .timer_int(timer_int)
    );

    // Cycle model: with TICK_DIV=1, mtime equals posedges seen since reset release.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    typedef struct {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic [63:0] data;
        logic        last;
    } rexp_t;
    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    rexp_t re;
    bexp_t be;

    logic        r_stall, b_stall;
    logic [63:0] r_prev_data;
    logic [3:0]  r_prev_id;
    logic        r_prev_last;
    logic [3:0]  b_prev_id;
    logic [1:0]  b_prev_resp;

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            r_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (r_stall) begin
                check("r_stall_hold", {rvalid, rlast, rid, rdata[58:0]},
                      {1'b1, r_prev_last, r_prev_id, r_prev_data[58:0]});
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL r_unexpected: got beat id %0d expected none", rid);
                end else begin
                    re = rq.pop_front();
                    check("rid", 64'(rid), 64'(re.id));
                    check("rresp", 64'(rresp), 64'(re.resp));
                    check("rdata", rdata, re.data);
                    check("rlast", 64'(rlast), 64'(re.last));
                end
            end
            r_stall = rvalid && !rready;
            r_prev_data = rdata; r_prev_id = rid; r_prev_last = rlast;

            if (b_stall) begin
                check("b_stall_hold", {59'd0, bvalid, bid}, {59'd0, 1'b1, b_prev_id});
                check("b_stall_resp", 64'(bresp), 64'(b_prev_resp));
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b_unexpected: got bid %0d expected none", bid);
                end else begin
                    be = bq.pop_front();
                    check("bid", 64'(bid), 64'(be.id));
                    check("bresp", 64'(bresp), 64'(be.resp));
                end
            end
            b_stall = bvalid && !bready;
            b_prev_id = bid; b_prev_resp = bresp;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_r(input logic [3:0] id, input logic [1:0] resp,
                          input logic [63:0] data, input logic last);
        rexp_t e;
        e.id = id; e.resp = resp; e.data = data; e.last = last;
        rq.push_back(e);
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
        bexp_t e;
        e.id = id; e.resp = resp;
        bq.push_back(e);
    endtask

    task automatic ar(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
        logic hs;
        int t = 0;
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        do begin
            @(negedge clk); hs = arready;
            step(); t++;
        end while (!hs && t < 20);
        arvalid = 1'b0;
        if (!hs) fail_now("ar_timeout");
    endtask

    task automatic aw_w(input logic [31:0] addr, input logic [63:0] data,
                        input logic [7:0] strb, input logic [3:0] id, output int cyc_w);
        logic hs;
        int t = 0;
        awaddr = addr; awid = id; awvalid = 1'b1;
        do begin
            @(negedge clk); hs = awready;
            step(); t++;
        end while (!hs && t < 20);
        awvalid = 1'b0;
        if (!hs) fail_now("aw_timeout");
        wdata = data; wstrb = strb; wlast = 1'b1; wvalid = 1'b1;
        t = 0;
        do begin
            @(negedge clk); hs = wready;
            step(); t++;
        end while (!hs && t < 20);
        wvalid = 1'b0; wlast = 1'b0;
        if (!hs) fail_now("w_timeout");
        cyc_w = cyc;
    endtask

    task automatic wait_r();
        int t = 0;
        while (rq.size() != 0 && t < 50) begin step(); t++; end
        if (rq.size() != 0) begin fail_now("r_drain"); rq.delete(); end
    endtask

    task automatic wait_b();
        int t = 0;
        while (bq.size() != 0 && t < 50) begin step(); t++; end
        if (bq.size() != 0) begin fail_now("b_drain"); bq.delete(); end
    endtask

    initial begin
        int cw;
        logic [63:0] exp_v;
        logic [5:0] pat;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 3'd3; awburst = 2'b01;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 3'd3; arburst = 2'b01;
        rready = 1;

        #12;
        check("rst_awready", 64'(awready), 64'd1);
        check("rst_arready", 64'(arready), 64'd1);
        check("rst_valids", {59'd0, wready, bvalid, rvalid, rlast, timer_int}, 64'd0);
        check("rst_payload", {52'd0, bid, bresp, rid, rresp}, 64'd0);
        check("rst_rdata", rdata, 64'd0);
        #10 rst_n = 1'b1;

        // Single-beat mtime read at cycle 10.
        step();
        while (cyc < 10) step();
        push_r(4'd1, OKAY, 64'd10, 1'b1);
        ar(A_MTIME, 8'd0, 4'd1);
        wait_r();

        // mtimecmp = 50, interrupt rises one cycle after mtime reaches 50.
        push_b(4'd2, OKAY);
        aw_w(A_CMP, 64'd50, 8'hFF, 4'd2, cw);
        wait_b();
        while (cyc < 50) step();
        check("tint_at_50", 64'(timer_int), 64'd0);
        step();
        check("tint_after_50", 64'(timer_int), 64'd1);
        push_b(4'd3, OKAY);
        aw_w(A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'd3, cw);
        check("tint_hold_cmp_write", 64'(timer_int), 64'd1);
        step();
        check("tint_clear", 64'(timer_int), 64'd0);
        wait_b();

        // Partial-strobe write to mtime.
        push_b(4'd4, OKAY);
        aw_w(A_MTIME, 64'hAABB_CCDD_0000_0000, 8'hFF, 4'd4, cw);
        wait_b();
        push_b(4'd5, OKAY);
        aw_w(A_MTIME, 64'h0000_0000_1234_5678, 8'h0F, 4'd5, cw);
        wait_b();
        exp_v = 64'hAABB_CCDD_1234_5678 + 64'(cyc - cw);
        push_r(4'd6, OKAY, exp_v, 1'b1);
        ar(A_MTIME, 8'd0, 4'd6);
        wait_r();

        // Unmapped read and write.
        push_r(4'd7, DECERR, 64'd0, 1'b1);
        ar(A_BAD, 8'd0, 4'd7);
        wait_r();
        push_b(4'd8, OKAY);
        aw_w(A_CMP, 64'h0123_4567_89AB_CDEF, 8'hFF, 4'd8, cw);
        wait_b();
        push_b(4'd9, DECERR);
        aw_w(A_BAD, 64'd0, 8'hFF, 4'd9, cw);
        wait_b();

        // Four-beat mtimecmp read with rready stalls.
        rready = 1'b0;
        for (int i = 0; i < 4; i++) push_r(4'd10, OKAY, 64'h0123_4567_89AB_CDEF, i == 3);
        ar(A_CMP, 8'd3, 4'd10);
        pat = 6'b101101;
        for (int i = 5; i >= 0; i--) begin
            rready = pat[i];
            step();
        end
        check("burst_done_rvalid", 64'(rvalid), 64'd0);
        check("burst_beats_left", 64'(rq.size()), 64'd0);
        rready = 1'b1;
        wait_r();

`ifdef YSYX_041461_CLINT_MSIP_EN
        push_b(4'd12, OKAY);
        aw_w(A_MSIP, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 4'd12, cw);
        wait_b();
        push_r(4'd12, OKAY, 64'd1, 1'b1);
        ar(A_MSIP, 8'd0, 4'd12);
        wait_r();
`else
        push_r(4'd12, DECERR, 64'd0, 1'b1);
        ar(A_MSIP, 8'd0, 4'd12);
        wait_r();
`endif

        // Reset while a write response is stalled.
        bready = 1'b0;
        push_b(4'd11, OKAY);
        aw_w(A_CMP, 64'd5, 8'hFF, 4'd11, cw);
        begin
            int t = 0;
            while (!bvalid && t < 10) begin step(); t++; end
        end
        step();
        check("bvalid_held", 64'(bvalid), 64'd1);
        rst_n = 1'b0;
        bq.delete();
        #2;
        check("abort_bvalid", 64'(bvalid), 64'd0);
        check("abort_awready", 64'(awready), 64'd1);
        check("abort_arready", 64'(arready), 64'd1);
        check("abort_tint", 64'(timer_int), 64'd0);
        step();
        rst_n = 1'b1;
        bready = 1'b1;
        step(); step();
        push_r(4'd13, OKAY, 64'd2, 1'b1);
        ar(A_MTIME, 8'd0, 4'd13);
        wait_r();
        push_r(4'd14, OKAY, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        ar(A_CMP, 8'd0, 4'd14);
        wait_r();

        step(); step();
        check("b_left", 64'(bq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
